// File: rtl/demux_1x8_4bit_reg_if.sv
// Bus bundle for the registered 1-to-8 4-bit demultiplexer.
// Producer side: in/in_valid/in_ready handshake plus lane select, enable and mode.
// Consumer side: eight 4-bit lane registers (a..h), per-lane valid and ack, cnt, full.
interface demux_1x8_4bit_reg_if;
    logic [3:0] in;
    logic       in_valid;
    logic       in_ready;
    logic       sel0;
    logic       sel1;
    logic       sel2;
    logic       enable;
    logic       mode;
    logic [7:0] ack;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] e;
    logic [3:0] f;
    logic [3:0] g;
    logic [3:0] h;
    logic [7:0] valid;
    logic [2:0] cnt;
    logic       full;

    // Environment side: drives producer inputs and acks, observes lanes.
    modport master (
        output in, in_valid, sel0, sel1, sel2, enable, mode, ack,
        input  in_ready, a, b, c, d, e, f, g, h, valid, cnt, full
    );

    // Demux side.
    modport slave (
        input  in, in_valid, sel0, sel1, sel2, enable, mode, ack,
        output in_ready, a, b, c, d, e, f, g, h, valid, cnt, full
    );
endinterface

// File: rtl/demux_1x8_4bit_reg.sv
// Purpose: steers one 4-bit word per accepted transfer into one of eight holding lanes.
// Latency: word accepted on edge N is visible on its lane with valid set after edge N.
// Backpressure: in_ready drops while enable is low or the target lane is occupied and not being acked.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, highest priority
//   bus   - slave side of demux_1x8_4bit_reg_if (handshake, select, ack, lane outputs)
module demux_1x8_4bit_reg (
    input  logic                        clk,
    input  logic                        reset,
    demux_1x8_4bit_reg_if.slave         bus
);

    logic [3:0] lane_q [0:7];
    logic [7:0] valid_q;
    logic [2:0] cnt_q;
    logic [2:0] target;
    logic       accept;

    // Round-robin pointer in auto mode, sel lines otherwise.
    assign target = bus.mode ? cnt_q : {bus.sel2, bus.sel1, bus.sel0};

    // A lane being acked on this edge is free to take the new word.
    assign bus.in_ready = bus.enable && (!valid_q[target] || bus.ack[target]);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                lane_q[i] <= 4'h0;
            end
            valid_q <= 8'h00;
            cnt_q   <= 3'd0;
        end else begin
            // Acks clear valid only; the stale data stays in the lane.
            // Acking an empty lane just rewrites a zero.
            for (int i = 0; i < 8; i++) begin
                if (bus.ack[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            // Written after the ack loop so a same-edge accept keeps the lane valid.
            if (accept) begin
                lane_q[target]  <= bus.in;
                valid_q[target] <= 1'b1;
                if (bus.mode) begin
                    cnt_q <= cnt_q + 3'd1;
                end
            end
        end
    end

    assign bus.a     = lane_q[0];
    assign bus.b     = lane_q[1];
    assign bus.c     = lane_q[2];
    assign bus.d     = lane_q[3];
    assign bus.e     = lane_q[4];
    assign bus.f     = lane_q[5];
    assign bus.g     = lane_q[6];
    assign bus.h     = lane_q[7];
    assign bus.valid = valid_q;
    assign bus.cnt   = cnt_q;
    assign bus.full  = &valid_q;

endmodule
